// File: rtl/ps2_pkg.sv
// Shared constants and FSM state type for the PS/2 receive path.
package ps2_pkg;

   localparam logic [7:0] PS2_EXTEND = 8'hE0;
   localparam logic [7:0] PS2_BREAK  = 8'hF0;
   localparam logic [7:0] PS2_BAT_OK = 8'hAA;

   typedef enum logic [1:0] {
      IDLE,
      DATA,
      PARITY,
      STOP
   } ps2_state_e;

endpackage

// File: rtl/ps2_frame_receiver_if.sv
// Byte interface between the PS/2 frame receiver and the keyboard decoder.
interface ps2_frame_receiver_if;

   logic [7:0] key_in;
   logic       is_extend;
   logic       is_break;
   logic       valid;
   logic       err;

   modport master (
      output key_in,
      output is_extend,
      output is_break,
      output valid,
      output err
   );

   modport slave (
      input key_in,
      input is_extend,
      input is_break,
      input valid,
      input err
   );

endinterface

// File: rtl/ps2_line_filter.sv
// Two-flop synchroniser plus FILTER_LEN-sample deglitch for the raw PS/2 clock.
// Emits a one-cycle strobe on each filtered 1->0 transition.
module ps2_line_filter #(
   parameter int unsigned FILTER_LEN = 8
) (
   input  logic clk,
   input  logic rst,
   input  logic line_raw,
   output logic fall
);

   localparam int unsigned CW = $clog2(FILTER_LEN + 1);

   logic [1:0]    sync_q, sync_d;
   logic          filt_q, filt_d;
   logic [CW-1:0] cnt_q,  cnt_d;
   logic          fall_q, fall_d;

   // Count consecutive synchronised samples that disagree with the filtered level.
   always_comb begin
      sync_d = {sync_q[0], line_raw};
      filt_d = filt_q;
      cnt_d  = '0;
      fall_d = 1'b0;
      if (sync_q[1] != filt_q) begin
         if (cnt_q == CW'(FILTER_LEN - 1)) begin
            filt_d = sync_q[1];
            fall_d = filt_q;
         end else begin
            cnt_d = cnt_q + CW'(1);
         end
      end
   end

   // Synchroniser, filter and strobe registers; idle line level is high.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync_q <= '1;
         filt_q <= 1'b1;
         cnt_q  <= '0;
         fall_q <= 1'b0;
      end else begin
         sync_q <= sync_d;
         filt_q <= filt_d;
         cnt_q  <= cnt_d;
         fall_q <= fall_d;
      end
   end

   assign fall = fall_q;

endmodule

// File: rtl/ps2_frame_receiver.sv
// PS/2 receive link layer: deserialises 11-bit frames from the keyboard and
// classifies each byte as extend prefix, break prefix or ordinary scan code.
module ps2_frame_receiver
   import ps2_pkg::*;
#(
   parameter int unsigned FILTER_LEN     = 8,
   parameter int unsigned TIMEOUT_CYCLES = 200000
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  ps2_clk,
   input  logic                  ps2_data,
   ps2_frame_receiver_if.master  bus
);

   localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

   logic          clk_fall;
   logic [1:0]    dsync_q, dsync_d;
   logic          data_s;

   ps2_state_e    state_q, state_d;
   logic [2:0]    bit_cnt_q, bit_cnt_d;
   logic [7:0]    shift_q, shift_d;
   logic          par_q, par_d;
   logic [TW-1:0] tmo_q, tmo_d;
   logic [7:0]    key_q, key_d;
   logic          ext_q, ext_d;
   logic          brk_q, brk_d;
   logic          vld_q, vld_d;
   logic          err_q, err_d;

   ps2_line_filter #(
      .FILTER_LEN(FILTER_LEN)
   ) u_clk_filt (
      .clk      (clk),
      .rst      (rst),
      .line_raw (ps2_clk),
      .fall     (clk_fall)
   );

   assign dsync_d = {dsync_q[0], ps2_data};
   assign data_s  = dsync_q[1];

   // Frame FSM, timeout counter and registered byte classification.
   always_comb begin
      state_d   = state_q;
      bit_cnt_d = bit_cnt_q;
      shift_d   = shift_q;
      par_d     = par_q;
      key_d     = key_q;
      ext_d     = 1'b0;
      brk_d     = 1'b0;
      vld_d     = 1'b0;
      err_d     = 1'b0;

      // Expiry is flagged as the counter steps onto TIMEOUT_CYCLES.
      tmo_d = (tmo_q == TW'(TIMEOUT_CYCLES)) ? tmo_q : tmo_q + TW'(1);
      if (clk_fall || state_q == IDLE) begin
         tmo_d = '0;
      end

      unique case (state_q)
         IDLE: begin
            if (clk_fall) begin
               if (!data_s) begin
                  state_d   = DATA;
                  bit_cnt_d = '0;
               end else begin
                  err_d = 1'b1;
               end
            end
         end
         DATA: begin
            if (clk_fall) begin
               shift_d   = {data_s, shift_q[7:1]};
               bit_cnt_d = bit_cnt_q + 3'd1;
               if (bit_cnt_q == 3'd7) begin
                  state_d = PARITY;
               end
            end
         end
         PARITY: begin
            if (clk_fall) begin
               par_d   = data_s;
               state_d = STOP;
            end
         end
         STOP: begin
            if (clk_fall) begin
               state_d = IDLE;
               if (data_s && ((^shift_q) ^ par_q)) begin
                  key_d = shift_q;
                  if (shift_q == PS2_EXTEND) begin
                     ext_d = 1'b1;
                  end else if (shift_q == PS2_BREAK) begin
                     brk_d = 1'b1;
                  end else begin
                     vld_d = 1'b1;
                  end
               end else begin
                  err_d = 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase

      // A fall strobe in the expiry cycle takes precedence over the timeout.
      if (state_q != IDLE && !clk_fall && tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
         state_d = IDLE;
         err_d   = 1'b1;
      end
   end

   // State, datapath and output pulse registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         dsync_q   <= '1;
         state_q   <= IDLE;
         bit_cnt_q <= '0;
         shift_q   <= '0;
         par_q     <= 1'b0;
         tmo_q     <= '0;
         key_q     <= '0;
         ext_q     <= 1'b0;
         brk_q     <= 1'b0;
         vld_q     <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         dsync_q   <= dsync_d;
         state_q   <= state_d;
         bit_cnt_q <= bit_cnt_d;
         shift_q   <= shift_d;
         par_q     <= par_d;
         tmo_q     <= tmo_d;
         key_q     <= key_d;
         ext_q     <= ext_d;
         brk_q     <= brk_d;
         vld_q     <= vld_d;
         err_q     <= err_d;
      end
   end

   assign bus.key_in    = key_q;
   assign bus.is_extend = ext_q;
   assign bus.is_break  = brk_q;
   assign bus.valid     = vld_q;
   assign bus.err       = err_q;

endmodule

// File: tb/tb_ps2_frame_receiver.sv
// Directed bench for ps2_frame_receiver: drives PS/2 frames on the raw lines
// and checks the classified byte pulses, latencies, errors and reset.
module tb_ps2_frame_receiver;

   localparam int F   = 8;
   localparam int T   = 600;
   localparam int H   = 40;
   localparam int LAT = F + 3;

   localparam int K_VLD = 0;
   localparam int K_EXT = 1;
   localparam int K_BRK = 2;
   localparam int K_ERR = 3;

   typedef struct {
      int         kind;
      logic [7:0] key;
      int         cyc;
   } ev_t;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic ps2_clk = 1'b1;
   logic ps2_data = 1'b1;

   int cyc = 0;
   int last_fall = 0;
   int overlap = 0;
   int n_chk = 0;
   int n_pass = 0;
   ev_t evq[$];

   ps2_frame_receiver_if bus();

   ps2_frame_receiver #(
      .FILTER_LEN     (F),
      .TIMEOUT_CYCLES (T)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .ps2_clk  (ps2_clk),
      .ps2_data (ps2_data),
      .bus      (bus)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Record every output pulse cycle; a stretched pulse shows up as extra events.
   always @(negedge clk) begin
      if (rst) begin
         if (bus.valid)     evq.push_back('{K_VLD, bus.key_in, cyc});
         if (bus.is_extend) evq.push_back('{K_EXT, bus.key_in, cyc});
         if (bus.is_break)  evq.push_back('{K_BRK, bus.key_in, cyc});
         if (bus.err)       evq.push_back('{K_ERR, bus.key_in, cyc});
         if (int'(bus.valid) + int'(bus.is_extend) + int'(bus.is_break) + int'(bus.err) > 1)
            overlap++;
      end
   end

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
   endtask

   task automatic wait_cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic send_bit(input logic b, input bit glitch);
      ps2_data = b;
      if (glitch) begin
         wait_cyc(H / 2);
         ps2_clk = 1'b0;
         wait_cyc(F - 2);
         ps2_clk = 1'b1;
         wait_cyc(H / 2 - (F - 2));
      end else begin
         wait_cyc(H);
      end
      ps2_clk   = 1'b0;
      last_fall = cyc;
      wait_cyc(H);
      ps2_clk = 1'b1;
   endtask

   task automatic send_frame(input logic [7:0] b, input logic par_flip, input logic stop,
                             input int glitch_bit);
      logic [10:0] bits;
      bits = {stop, (~^b) ^ par_flip, b, 1'b0};
      for (int i = 0; i < 11; i++) send_bit(bits[i], i == glitch_bit);
      ps2_data = 1'b1;
      wait_cyc(H);
   endtask

   task automatic expect_ev(input string tag, input int kind, input logic [7:0] key,
                            input int exp_cyc);
      ev_t e;
      check_eq({tag, "_present"}, (evq.size() > 0) ? 32'd1 : 32'd0, 32'd1);
      if (evq.size() > 0) begin
         e = evq.pop_front();
         check_eq({tag, "_kind"}, e.kind, kind);
         check_eq({tag, "_key"},  {24'd0, e.key}, {24'd0, key});
         check_eq({tag, "_cyc"},  e.cyc, exp_cyc);
      end
   endtask

   task automatic expect_quiet(input string tag);
      check_eq({tag, "_no_extra"}, evq.size(), 0);
      evq.delete();
   endtask

   task automatic check_outs_zero(input string tag);
      check_eq({tag, "_key"}, {24'd0, bus.key_in}, 32'd0);
      check_eq({tag, "_pulses"},
               {28'd0, bus.valid, bus.is_extend, bus.is_break, bus.err}, 32'd0);
   endtask

   initial begin
      logic [7:0] part;

      wait_cyc(5);
      check_outs_zero("reset");
      rst = 1'b1;
      wait_cyc(30);
      check_outs_zero("post_reset");
      expect_quiet("idle");

      // Single scan code with latency check from the raw stop-bit edge.
      send_frame(8'h1C, 1'b0, 1'b1, -1);
      expect_ev("f1c", K_VLD, 8'h1C, last_fall + LAT);
      expect_quiet("f1c");

      // Extend prefix then scan code.
      send_frame(8'hE0, 1'b0, 1'b1, -1);
      expect_ev("e0", K_EXT, 8'hE0, last_fall + LAT);
      send_frame(8'h75, 1'b0, 1'b1, -1);
      expect_ev("e0_75", K_VLD, 8'h75, last_fall + LAT);
      expect_quiet("ext_seq");

      // Break sequences.
      send_frame(8'hF0, 1'b0, 1'b1, -1);
      expect_ev("f0", K_BRK, 8'hF0, last_fall + LAT);
      send_frame(8'h1C, 1'b0, 1'b1, -1);
      expect_ev("f0_1c", K_VLD, 8'h1C, last_fall + LAT);
      send_frame(8'hE0, 1'b0, 1'b1, -1);
      expect_ev("x_e0", K_EXT, 8'hE0, last_fall + LAT);
      send_frame(8'hF0, 1'b0, 1'b1, -1);
      expect_ev("x_f0", K_BRK, 8'hF0, last_fall + LAT);
      send_frame(8'h75, 1'b0, 1'b1, -1);
      expect_ev("x_75", K_VLD, 8'h75, last_fall + LAT);
      expect_quiet("brk_seq");

      // Parity error then stop-bit error; key_in holds the last good byte.
      send_frame(8'h1C, 1'b1, 1'b1, -1);
      expect_ev("bad_par", K_ERR, 8'h75, last_fall + LAT);
      send_frame(8'h5A, 1'b0, 1'b0, -1);
      expect_ev("bad_stop", K_ERR, 8'h75, last_fall + LAT);
      expect_quiet("errs");
      check_eq("key_held", {24'd0, bus.key_in}, 32'h75);

      // Partial frame (start + 4 data bits), then silence until timeout.
      part = 8'h0B;
      send_bit(1'b0, 1'b0);
      for (int i = 0; i < 4; i++) send_bit(part[i], 1'b0);
      ps2_data = 1'b1;
      wait_cyc(T + F + 20);
      expect_ev("timeout", K_ERR, 8'h75, last_fall + LAT + T);
      expect_quiet("timeout");
      send_frame(8'hAA, 1'b0, 1'b1, -1);
      expect_ev("bat_aa", K_VLD, 8'hAA, last_fall + LAT);
      expect_quiet("bat");

      // Short low glitch on ps2_clk during a data bit must be ignored.
      send_frame(8'h1C, 1'b0, 1'b1, 3);
      expect_ev("glitch", K_VLD, 8'h1C, last_fall + LAT);
      expect_quiet("glitch");

      // Reset asserted mid-frame during bit 4.
      part = 8'h5A;
      send_bit(1'b0, 1'b0);
      for (int i = 0; i < 4; i++) send_bit(part[i], 1'b0);
      ps2_data = part[4];
      wait_cyc(H);
      ps2_clk = 1'b0;
      wait_cyc(20);
      rst = 1'b0;
      #1;
      check_outs_zero("mid_reset");
      @(negedge clk);
      ps2_clk  = 1'b1;
      ps2_data = 1'b1;
      wait_cyc(20);
      rst = 1'b1;
      wait_cyc(100);
      expect_quiet("after_reset");
      send_frame(8'h5A, 1'b0, 1'b1, -1);
      expect_ev("post_rst_5a", K_VLD, 8'h5A, last_fall + LAT);
      expect_quiet("final");

      check_eq("no_overlap", overlap, 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
